// File: rtl/shift_pipe_if.sv
// Handshake bundle for shift_pipe: operand/amount/op in, shifted result out, plus flush and busy.
interface shift_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             busy;

  modport master (
    output flush, in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero, busy
  );

  modport slave (
    input  flush, in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero, busy
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL): stage k shifts by 2^k when amount bit k is set,
// with valid/ready on both ends and a combinational ready chain back to the input.
module shift_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input logic         clk,
  input logic         rst,
  shift_pipe_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic             valid_q [SHW];
  logic [WIDTH-1:0] data_q  [SHW];
  logic [1:0]       op_q    [SHW];
  logic [SHW-1:0]   amt_q   [SHW];
  logic             out_zero_q;

  logic [SHW-1:0]   adv;
  logic [SHW-1:0]   load;
  logic             src_valid [SHW];
  logic [WIDTH-1:0] src_data  [SHW];
  logic [1:0]       src_op    [SHW];
  logic [SHW-1:0]   src_amt   [SHW];
  logic [WIDTH-1:0] nxt_data  [SHW];
  logic [SHW-1:0]   nxt_amt   [SHW];
  logic             busy_c;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       op,
                                                input int unsigned      s);
    logic [WIDTH-1:0] r;
    unique case (op)
      OP_SLL:  r = d << s;
      OP_SRL:  r = d >> s;
      OP_SRA:  r = WIDTH'($signed(d) >>> s);
      default: r = (d << s) | (d >> (WIDTH - s));
    endcase
    return r;
  endfunction

  // Ready chain from the output back: a stage loads when it is empty or its contents move on.
  always_comb begin
    logic rdy;
    adv  = '0;
    load = '0;
    rdy  = bus.out_ready;
    for (int k = int'(SHW) - 1; k >= 0; k--) begin
      adv[k]  = valid_q[k] & rdy;
      load[k] = !valid_q[k] | adv[k];
      rdy     = load[k];
    end
  end

  // Stage inputs and the per-stage conditional shift; each stage retires its own amount bit.
  always_comb begin
    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.in_data;
    src_op[0]    = bus.in_op;
    src_amt[0]   = bus.in_amt;
    for (int k = 1; k < int'(SHW); k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_op[k]    = op_q[k-1];
      src_amt[k]   = amt_q[k-1];
    end
    for (int k = 0; k < int'(SHW); k++) begin
      nxt_amt[k]    = src_amt[k];
      nxt_amt[k][k] = 1'b0;
      nxt_data[k]   = src_amt[k][k] ? shift_by(src_data[k], src_op[k], 32'(1) << k)
                                    : src_data[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(SHW); k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        op_q[k]    <= '0;
        amt_q[k]   <= '0;
      end
      out_zero_q <= 1'b0;
    end else begin
      for (int k = 0; k < int'(SHW); k++) begin
        if (bus.flush) begin
          valid_q[k] <= 1'b0;
        end else if (load[k]) begin
          valid_q[k] <= src_valid[k];
        end
        if (!bus.flush && load[k] && src_valid[k]) begin
          data_q[k] <= nxt_data[k];
          op_q[k]   <= src_op[k];
          amt_q[k]  <= nxt_amt[k];
        end
      end
      if (!bus.flush && load[SHW-1] && src_valid[SHW-1]) begin
        out_zero_q <= (nxt_data[SHW-1] == '0);
      end
    end
  end

  always_comb begin
    busy_c = 1'b0;
    for (int k = 0; k < int'(SHW); k++) begin
      busy_c = busy_c | valid_q[k];
    end
  end

  assign bus.in_ready  = !bus.flush && load[0];
  assign bus.out_valid = valid_q[SHW-1];
  assign bus.out_data  = data_q[SHW-1];
  assign bus.out_zero  = out_zero_q;
  assign bus.busy      = busy_c;
endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: scoreboard filled at acceptance, drained by an output monitor.
module tb_shift_pipe;
  localparam int unsigned SHW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_pipe_if #(.WIDTH(16)) bus ();
  shift_pipe_if #(.WIDTH(32)) bus32 ();

  shift_pipe #(.WIDTH(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  shift_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  typedef struct {
    logic [15:0] data;
    int          acc;
  } ent_t;

  ent_t sb[$];
  ent_t mon_e;
  int   cmp_cnt  = 0;
  int   err_cnt  = 0;
  int   edge_cnt = 0;
  int   acc_cnt  = 0;
  bit   chk_lat  = 1'b0;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model written bit-by-bit, independent of the shift operators used in the RTL.
  function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] a, input logic [1:0] o);
    logic [15:0] r;
    r = '0;
    case (o)
      2'd0: for (int i = 0; i < 16; i++) r[i] = (i < int'(a)) ? 1'b0 : d[i-int'(a)];
      2'd1: for (int i = 0; i < 16; i++) r[i] = (i + int'(a) > 15) ? 1'b0 : d[i+int'(a)];
      2'd2: for (int i = 0; i < 16; i++) r[i] = (i + int'(a) > 15) ? d[15] : d[i+int'(a)];
      default: for (int i = 0; i < 16; i++) r[(i+int'(a))%16] = d[i];
    endcase
    return r;
  endfunction

  // Called at posedge+1; holds the op until accepted, leaves in_valid high on return.
  task automatic send(input logic [15:0] d, input logic [3:0] a, input logic [1:0] o,
                      input logic [15:0] e);
    bit got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_op    = o;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      got = bus.in_ready;
      if (got) begin
        sb.push_back('{e, edge_cnt + 1});
        acc_cnt++;
      end
      @(posedge clk);
      #1;
      if (got) break;
    end
    if (!got) check("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: every transferred result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      check("result_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("out_data", 32'(bus.out_data), 32'(mon_e.data));
        check("out_zero", 32'(bus.out_zero), 32'(mon_e.data == 16'h0));
        if (chk_lat) check("latency", 32'(edge_cnt - mon_e.acc), 32'(SHW - 1));
      end
    end
  end

  logic [15:0] sd [10] = '{16'h00F1, 16'h0007, 16'h8000, 16'h8000, 16'h4000,
                           16'h8001, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
  logic [3:0]  sa [10] = '{4'd4, 4'd13, 4'd15, 4'd15, 4'd14, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
  logic [1:0]  so [10] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [15:0] se [10] = '{16'h0F10, 16'hE000, 16'h0001, 16'hFFFF, 16'h0001,
                           16'h0003, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};

  logic [15:0] bd [6];
  logic [3:0]  ba [6];
  logic [1:0]  bo [6];
  logic [15:0] rd;
  logic [3:0]  ra;
  logic [1:0]  ro;
  int          lat;

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0;
    bus.in_op = '0; bus.out_ready = 1'b1;
    bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_amt = '0;
    bus32.in_op = '0; bus32.out_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_zero",  32'(bus.out_zero),  32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Single ops, one at a time
    chk_lat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(sd[i], sa[i], so[i], se[i]);
      idle();
      wait_cycles(6);
    end
    check("single_drained", 32'(sb.size()), 32'd0);

    // Back-to-back random stream, including zero and non-zero edge cases
    for (int i = 0; i < 16; i++) begin
      rd = 16'($urandom); ra = 4'($urandom_range(0, 15)); ro = 2'($urandom_range(0, 3));
      if (i == 3) begin rd = 16'h0001; ra = 4'd1; ro = 2'd1; end
      if (i == 5) begin rd = 16'h0001; ra = 4'd0; ro = 2'd0; end
      send(rd, ra, ro, model(rd, ra, ro));
    end
    idle();
    wait_cycles(8);
    check("stream_drained", 32'(sb.size()), 32'd0);

    // Backpressure: capacity of SHW ops, hold, then drain without gaps
    chk_lat = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bd[i] = 16'h1111 * 16'(i + 1); ba[i] = 4'(i + 2); bo[i] = 2'(i % 4);
    end
    bus.out_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(bd[i], ba[i], bo[i], model(bd[i], ba[i], bo[i]));
        idle();
      end
      begin
        wait_cycles(10);
        check("bp_accepted",  32'(acc_cnt),       32'd4);
        check("bp_in_ready",  32'(bus.in_ready),  32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_hold_data", 32'(bus.out_data),  32'(model(bd[0], ba[0], bo[0])));
        bus.out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          check("bp_no_gap", 32'(bus.out_valid), 32'd1);
        end
      end
    join
    wait_cycles(8);
    check("bp_drained", 32'(sb.size()), 32'd0);

    // Flush with 3 ops in flight and a competing input
    chk_lat = 1'b1;
    send(16'h00FF, 4'd3, 2'd0, model(16'h00FF, 4'd3, 2'd0));
    send(16'hF00F, 4'd5, 2'd3, model(16'hF00F, 4'd5, 2'd3));
    send(16'h9000, 4'd2, 2'd2, model(16'h9000, 4'd2, 2'd2));
    bus.flush = 1'b1;
    bus.in_data = 16'h1234; bus.in_amt = 4'd1; bus.in_op = 2'd0;
    @(negedge clk);
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    check("flush_pre_busy", 32'(bus.busy),     32'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    idle();
    sb.delete();
    @(negedge clk);
    check("flush_busy",      32'(bus.busy),      32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    wait_cycles(8);

    // Asynchronous reset with 2 ops in flight
    bus.out_ready = 1'b0;
    send(16'h0101, 4'd2, 2'd0, model(16'h0101, 4'd2, 2'd0));
    send(16'h0202, 4'd3, 2'd0, model(16'h0202, 4'd3, 2'd0));
    idle();
    wait_cycles(4);
    check("arst_pre_valid", 32'(bus.out_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_data",  32'(bus.out_data),  32'd0);
    check("arst_busy",      32'(bus.busy),      32'd0);
    #1 rst = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(16'h0001, 4'd15, 2'd0, 16'h8000);
    idle();
    wait_cycles(6);
    check("arst_drained", 32'(sb.size()), 32'd0);

    // WIDTH=32 instance: SRA of the sign bit across all five stages
    bus32.in_valid = 1'b1;
    bus32.in_data  = 32'h8000_0000;
    bus32.in_amt   = 5'd31;
    bus32.in_op    = 2'd2;
    @(negedge clk);
    check("w32_in_ready", 32'(bus32.in_ready), 32'd1);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus32.out_valid) break;
      @(posedge clk);
      lat++;
    end
    check("w32_latency",  32'(lat),              32'd4);
    check("w32_out_data", bus32.out_data,        32'hFFFF_FFFF);
    check("w32_out_zero", 32'(bus32.out_zero),   32'd0);

    check("final_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
